// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state encoding, SCL quarter indices and R/W bit value.
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK1  = 3'd3,
        DATA  = 3'd4,
        ACK2  = 3'd5,
        STOP  = 3'd6
    } state_e;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
    localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/i2c_qtick_gen.sv
// i2c_qtick_gen: CLK_DIV divider producing one-cycle quarter-period ticks while enabled.
// Ports: clk_i, reset_i (sync, active high), en_i (count enable, counter held at 0 otherwise),
//        qtick_o (high on the last clock of each SCL quarter).
module i2c_qtick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic qtick_o
);
    localparam int W = $clog2(CLK_DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign qtick_o = en_i && (cnt_q == W'(CLK_DIV - 1));
    assign cnt_d   = (!en_i || qtick_o) ? '0 : cnt_q + W'(1);
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer: I2C master that writes one {addr, data} byte pair per accepted command.
// Ports: clk_i, reset_i (sync, active high); host side cmd_valid_i/cmd_ready_o handshake with
//        cmd_addr_i (7b) and cmd_data_i (8b), status busy_o, done_o (1-cycle), nack_o (valid with done);
//        bus side scl_o, sda_out_o, sda_oe_o (pad drives sda_out when oe, else released), sda_in_i.
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic       scl_o,
    output logic       sda_out_o,
    output logic       sda_oe_o,
    input  logic       sda_in_i
);
    state_e     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       flag_q, flag_d, nack_q, nack_d, done_q, done_d;
    logic       scl_q, scl_d, sda_q, sda_d, oe_q, oe_d;
    logic       qtick;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (busy_o),
        .qtick_o (qtick)
    );

    assign cmd_ready_o = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign nack_o      = nack_q;
    assign scl_o       = scl_q;
    assign sda_out_o   = sda_q;
    assign sda_oe_o    = oe_q;

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        flag_d  = flag_q;
        nack_d  = nack_q;
        done_d  = 1'b0;
        if (state_q == IDLE && cmd_valid_i) begin
            state_d = START;
            qtr_d   = Q0;
            bit_d   = 3'd7;
            shift_d = {cmd_addr_i, RW_WRITE};
            data_d  = cmd_data_i;
            flag_d  = 1'b0;
            nack_d  = 1'b0;
        end else if (qtick) begin
            qtr_d = qtr_q + 2'd1;
            case (state_q)
                START: if (qtr_q == Q1) begin
                    state_d = ADDR;
                    qtr_d   = Q0;
                end
                ADDR, DATA: if (qtr_q == Q3) begin
                    if (bit_q == 3'd0) state_d = (state_q == ADDR) ? ACK1 : ACK2;
                    bit_d   = bit_q - 3'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                end
                ACK1, ACK2: begin
                    if (qtr_q == Q2) flag_d = flag_q | sda_in_i;
                    // An address NACK skips the data phase entirely.
                    if (qtr_q == Q3) begin
                        state_d = (state_q == ACK2 || flag_q) ? STOP : DATA;
                        bit_d   = 3'd7;
                        shift_d = data_q;
                    end
                end
                STOP: if (qtr_q == Q3) begin
                    state_d = IDLE;
                    nack_d  = flag_q;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Bus pins are registered from the next state so they move together with the FSM.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        oe_d  = 1'b1;
        case (state_d)
            START:      sda_d = 1'b0;
            ADDR, DATA: begin
                scl_d = qtr_d[1];
                sda_d = shift_d[7];
            end
            ACK1, ACK2: begin
                scl_d = qtr_d[1];
                oe_d  = 1'b0;
            end
            STOP: begin
                scl_d = qtr_d != Q0;
                sda_d = qtr_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            qtr_q   <= Q0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            flag_q  <= 1'b0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
        end
    end
endmodule
